// File: rtl/hw_button_ctrl.sv
// Avalon-MM push-button controller: 2-flop sync, per-button debounce FSM, press edge capture
// and maskable level irq. Define HW_BUTTON_LONGPRESS_EN to add sticky long-press capture.
module hw_button_ctrl #(
    parameter int WIDTH            = 4,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int CNT_W            = 26,
    parameter int ACTIVE_LOW       = 1,
    parameter int LONGPRESS_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        STABLE_UP = 2'd0,
        WAIT_DN   = 2'd1,
        STABLE_DN = 2'd2,
        WAIT_UP   = 2'd3
    } db_state_t;

    localparam logic [WIDTH-1:0] IDLE_PINS = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
`ifdef HW_BUTTON_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DONE   = CNT_W'(LONGPRESS_CYCLES);
`else
    localparam int unused_lp_cycles = LONGPRESS_CYCLES;
`endif

    logic [WIDTH-1:0] sync_q1, sync_q2, s;
    db_state_t        state     [WIDTH];
    db_state_t        state_nxt [WIDTH];
    logic [CNT_W-1:0] cnt       [WIDTH];
    logic [CNT_W-1:0] cnt_nxt   [WIDTH];
    logic [WIDTH-1:0] pressed, press_evt;
    logic [WIDTH-1:0] irqmask, edgecap, longcap;
    logic [WIDTH-1:0] clr_mask;
    logic             wr;
    logic             unused_wdata;

    assign s            = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;
    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^(writedata >> WIDTH);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of
    // statement order; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= IDLE_PINS;
            sync_q2 <= IDLE_PINS;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= STABLE_UP;
                cnt[i]   <= '0;
            end
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // NOTE: every always_comb output gets a default before the case so no path infers a latch.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                STABLE_UP: begin
                    if (s[i]) begin
                        state_nxt[i] = WAIT_DN;
                        cnt_nxt[i]   = '0;
                    end
                end
                WAIT_DN: begin
                    if (!s[i]) begin
                        state_nxt[i] = STABLE_UP;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = STABLE_DN;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] != CNT_MAX) begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                STABLE_DN: begin
                    if (!s[i]) begin
                        state_nxt[i] = WAIT_UP;
                        cnt_nxt[i]   = '0;
                    end
`ifdef HW_BUTTON_LONGPRESS_EN
                    else if (cnt[i] != LP_DONE) begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
`endif
                end
                WAIT_UP: begin
                    if (s[i]) begin
                        state_nxt[i] = STABLE_DN;
`ifdef HW_BUTTON_LONGPRESS_EN
                        // A release glitch parks the timer as spent so one press never flags twice.
                        cnt_nxt[i]   = LP_DONE;
`else
                        cnt_nxt[i]   = '0;
`endif
                    end else if (cnt[i] == DB_LAST) begin
                        state_nxt[i] = STABLE_UP;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] != CNT_MAX) begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = STABLE_UP;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pressed   = '0;
        press_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pressed[i]   = (state[i] == STABLE_DN) || (state[i] == WAIT_UP);
            press_evt[i] = (state[i] == WAIT_DN) && s[i] && (cnt[i] == DB_LAST);
        end
    end

    assign clr_mask = wr ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr && address == 2'd1)
                irqmask <= writedata[WIDTH-1:0];
            // The OR after the clear lets a same-cycle event win over a W1C.
            edgecap <= (edgecap & ~((address == 2'd2) ? clr_mask : '0)) | press_evt;
        end
    end

`ifdef HW_BUTTON_LONGPRESS_EN
    logic [WIDTH-1:0] long_evt;

    always_comb begin
        long_evt = '0;
        for (int i = 0; i < WIDTH; i++)
            long_evt[i] = (state[i] == STABLE_DN) && s[i] && (cnt[i] == LP_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            longcap <= '0;
        else
            longcap <= (longcap & ~((address == 2'd3) ? clr_mask : '0)) | long_evt;
    end
`else
    assign longcap = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(pressed);
                2'd1:    readdata <= 32'(irqmask);
                2'd2:    readdata <= 32'(edgecap);
                default: readdata <= 32'(longcap);
            endcase
            irq <= |((edgecap | longcap) & irqmask);
        end
    end

endmodule

// File: tb/tb_hw_button_ctrl.sv
// Self-checking bench for hw_button_ctrl: a run-length reference model checked every cycle,
// plus directed literal checks. Honours HW_BUTTON_LONGPRESS_EN for the long-press expectation.
module tb_hw_button_ctrl;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int LP = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [W-1:0] in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;

    hw_button_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(26), .ACTIVE_LOW(1), .LONGPRESS_CYCLES(LP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's level flips after D+1 consecutive synchronised samples
    // that disagree with it; a long press is LP agreeing pressed samples after the press.
    logic [W-1:0] p1, p2, m_lvl, m_mask, m_edge, m_long;
    int           run  [W];
    int           held [W];
    bit           long_ok [W];
    logic [31:0]  exp_rd;
    logic         exp_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1 = 4'hF; p2 = 4'hF;
            m_lvl = '0; m_mask = '0; m_edge = '0; m_long = '0;
            for (int i = 0; i < W; i++) begin
                run[i] = 0; held[i] = 0; long_ok[i] = 1'b0;
            end
            exp_rd = '0; exp_irq = 1'b0;
        end else begin
            logic [W-1:0] s, set_e, set_l, clr;
            bit wr;
            case (address)
                2'd0:    exp_rd = {28'd0, m_lvl};
                2'd1:    exp_rd = {28'd0, m_mask};
                2'd2:    exp_rd = {28'd0, m_edge};
                default: exp_rd = {28'd0, m_long};
            endcase
            exp_irq = |((m_edge | m_long) & m_mask);
            wr = chipselect && !write_n;
            s = ~p2;
            set_e = '0; set_l = '0;
            for (int i = 0; i < W; i++) begin
                if (s[i] != m_lvl[i]) begin
                    run[i]++;
                    if (m_lvl[i]) long_ok[i] = 1'b0;
                    if (run[i] == D + 1) begin
                        m_lvl[i] = s[i];
                        run[i] = 0;
                        if (s[i]) begin
                            set_e[i] = 1'b1; long_ok[i] = 1'b1; held[i] = 0;
                        end
                    end
                end else begin
                    run[i] = 0;
                    if (m_lvl[i] && long_ok[i]) begin
                        held[i]++;
                        if (held[i] == LP) begin
                            set_l[i] = 1'b1; long_ok[i] = 1'b0;
                        end
                    end
                end
            end
`ifndef HW_BUTTON_LONGPRESS_EN
            set_l = '0;
`endif
            clr = wr ? writedata[W-1:0] : '0;
            m_edge = (m_edge & ~((address == 2'd2) ? clr : '0)) | set_e;
            m_long = (m_long & ~((address == 2'd3) ? clr : '0)) | set_l;
            if (wr && address == 2'd1) m_mask = writedata[W-1:0];
            p2 = p1; p1 = in_port;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_readdata", readdata, exp_rd);
            check("model_irq", {31'd0, irq}, {31'd0, exp_irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        tick(1);
        check(name, readdata, exp);
    endtask

    initial begin
        tick(2);
        armed = 1'b1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        #1 reset_n = 1'b1;
        for (int a = 0; a < 4; a++) read_reg(a[1:0], 32'h0, "reset_reg_read");

        // Clean press on button 0: level visible on readdata at the 8th edge.
        address = 2'd0;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 7) check("press_not_yet", readdata, 32'h0);
            if (k == 8) check("press_data", readdata, 32'h1);
        end
        read_reg(2'd2, 32'h1, "press_edgecap");
        in_port[0] = 1'b1;
        tick(12);
        read_reg(2'd0, 32'h0, "release_data");
        read_reg(2'd2, 32'h1, "release_no_clear");
        write_reg(2'd2, 32'h1);
        read_reg(2'd2, 32'h0, "w1c_edgecap");

        // Bounce shorter than the debounce window on button 1.
        in_port[1] = 1'b0;
        tick(3);
        in_port[1] = 1'b1;
        tick(15);
        read_reg(2'd0, 32'h0, "bounce_data");
        read_reg(2'd2, 32'h0, "bounce_edgecap");

        // IRQ path.
        write_reg(2'd1, 32'h1);
        read_reg(2'd1, 32'h1, "irqmask_rw");
        in_port[0] = 1'b0;
        tick(7);
        check("irq_before", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_set", {31'd0, irq}, 32'h1);
        in_port[0] = 1'b1;
        tick(12);
        write_reg(2'd2, 32'h1);
        check("irq_hold_on_clear_edge", {31'd0, irq}, 32'h1);
        tick(1);
        check("irq_after_w1c", {31'd0, irq}, 32'h0);

        // Collision: W1C on the very edge button 2 commits its press.
        in_port[2] = 1'b0;
        tick(6);
        write_reg(2'd2, 32'h4);
        read_reg(2'd2, 32'h4, "collision_set_wins");
        in_port[2] = 1'b1;
        tick(12);
        write_reg(2'd2, 32'h4);
        read_reg(2'd2, 32'h0, "collision_cleared");

        // Long press on button 3.
        in_port[3] = 1'b0;
        tick(30);
        in_port[3] = 1'b1;
        tick(12);
`ifdef HW_BUTTON_LONGPRESS_EN
        read_reg(2'd3, 32'h8, "longcap");
`else
        read_reg(2'd3, 32'h0, "longcap");
`endif
        read_reg(2'd2, 32'h8, "long_edgecap");
        read_reg(2'd0, 32'h0, "long_released");

        // RO register and unused upper bits.
        write_reg(2'd0, 32'hF);
        read_reg(2'd0, 32'h0, "data_ro");
        write_reg(2'd1, 32'hFFFF_FFFF);
        read_reg(2'd1, 32'hF, "irqmask_upper_zero");
        tick(2);
        check("irq_from_edgecap3", {31'd0, irq}, 32'h1);

        // Reset in the middle of a debounce discards the pending press.
        write_reg(2'd2, 32'hF);
        write_reg(2'd3, 32'hF);
        in_port[1] = 1'b0;
        tick(4);
        #1 reset_n = 1'b0;
        in_port[1] = 1'b1;
        tick(2);
        #1 reset_n = 1'b1;
        tick(12);
        read_reg(2'd0, 32'h0, "midreset_data");
        read_reg(2'd2, 32'h0, "midreset_edgecap");
        read_reg(2'd1, 32'h0, "midreset_irqmask");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
